// File: rtl/packet_buffer_pkg.sv
// Packet buffer shared definitions: frame limits and scheduler states.
package packet_buffer_pkg;

    localparam int MAX_ETH_FRAME_LENGTH = 1518;
    localparam int PKT_LEN_WIDTH = $clog2(MAX_ETH_FRAME_LENGTH + 1);

    typedef enum logic [0:0] {
        SCHED_ARB,
        SCHED_STREAM
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest request index at or after ptr
// wins, wrapping modulo NUM_REQ (NUM_REQ must be a power of two).
module rr_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        grant_idx   = ptr;
        grant_valid = 1'b0;
        idx         = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + IDX_W'(i);
            if (req[idx]) begin
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_buffer_read_scheduler.sv
// Drains per-lane byte FIFOs into one AXI4-Stream master, one whole
// packet at a time, round-robin over lanes holding a length descriptor.
module packet_buffer_read_scheduler
    import packet_buffer_pkg::*;
#(
    parameter int NUM_LANES  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = PKT_LEN_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [LEN_WIDTH-1:0]         desc_len_i    [NUM_LANES],
    input  logic [NUM_LANES-1:0]         desc_valid_i,
    output logic [NUM_LANES-1:0]         desc_ready_o,
    input  logic [DATA_WIDTH-1:0]        lane_tdata_i  [NUM_LANES],
    input  logic [NUM_LANES-1:0]         lane_tvalid_i,
    output logic [NUM_LANES-1:0]         lane_tready_o,
    output logic [DATA_WIDTH-1:0]        m_tdata_o,
    output logic                         m_tvalid_o,
    output logic                         m_tlast_o,
    input  logic                         m_tready_i,
    output logic [$clog2(NUM_LANES)-1:0] m_lane_o,
    output logic [31:0]                  pkt_count_o,
    output logic                         err_zero_len_o
);

    localparam int LANE_W = $clog2(NUM_LANES);

    sched_state_t         state_q;
    sched_state_t         state_d;
    logic [LANE_W-1:0]    rr_ptr_q;
    logic [LANE_W-1:0]    lane_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic [31:0]          pkt_count_q;
    logic                 err_q;
    logic                 arb_en_q;

    logic [LANE_W-1:0]    grant_idx;
    logic                 grant_valid;
    logic [LEN_WIDTH-1:0] grant_len;
    logic                 grant_fire;
    logic                 beat;

    rr_arbiter #(
        .NUM_REQ (NUM_LANES)
    ) u_arb (
        .req         (desc_valid_i),
        .ptr         (rr_ptr_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // arb_en_q holds off grants for the first cycle out of reset.
    assign grant_len  = desc_len_i[grant_idx];
    assign grant_fire = !rst_i && arb_en_q && grant_valid
                        && (state_q == SCHED_ARB);
    assign beat       = m_tvalid_o && m_tready_i;

    always_comb begin
        state_d       = state_q;
        desc_ready_o  = '0;
        lane_tready_o = '0;
        m_tdata_o     = '0;
        m_tvalid_o    = 1'b0;
        m_tlast_o     = 1'b0;
        unique case (state_q)
            SCHED_ARB: begin
                if (grant_fire) begin
                    desc_ready_o[grant_idx] = 1'b1;
                    if (grant_len != '0) begin
                        state_d = SCHED_STREAM;
                    end
                end
            end
            SCHED_STREAM: begin
                if (!rst_i) begin
                    m_tdata_o             = lane_tdata_i[lane_q];
                    m_tvalid_o            = lane_tvalid_i[lane_q];
                    lane_tready_o[lane_q] = m_tready_i;
                    m_tlast_o = m_tvalid_o
                                && (remaining_q == LEN_WIDTH'(1));
                    if (m_tlast_o && m_tready_i) begin
                        state_d = SCHED_ARB;
                    end
                end
            end
            default: state_d = SCHED_ARB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= SCHED_ARB;
            rr_ptr_q    <= '0;
            lane_q      <= '0;
            remaining_q <= '0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
            arb_en_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            arb_en_q <= 1'b1;
            err_q    <= 1'b0;
            if (grant_fire) begin
                remaining_q <= grant_len;
                lane_q      <= grant_idx;
                rr_ptr_q    <= grant_idx + LANE_W'(1);
                err_q       <= (grant_len == '0);
            end
            if (beat) begin
                remaining_q <= remaining_q - LEN_WIDTH'(1);
                if (remaining_q == LEN_WIDTH'(1)) begin
                    pkt_count_q <= pkt_count_q + 32'd1;
                end
            end
        end
    end

    assign m_lane_o       = lane_q;
    assign pkt_count_o    = pkt_count_q;
    assign err_zero_len_o = err_q;

endmodule

// File: tb/tb_packet_buffer_read_scheduler.sv
// Bench for packet_buffer_read_scheduler: queue-based lane sources and a
// round-robin packet-order model predicting every output beat.
module tb_packet_buffer_read_scheduler;

    localparam int NL = 8;
    localparam int DW = 8;
    localparam int LW = 11;

    typedef struct {
        int         lane;
        logic [7:0] data;
        bit         last;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [LW-1:0] desc_len_i    [NL];
    logic [NL-1:0] desc_valid_i;
    logic [NL-1:0] desc_ready_o;
    logic [DW-1:0] lane_tdata_i  [NL];
    logic [NL-1:0] lane_tvalid_i;
    logic [NL-1:0] lane_tready_o;
    logic [DW-1:0] m_tdata_o;
    logic          m_tvalid_o;
    logic          m_tlast_o;
    logic          m_tready_i;
    logic [2:0]    m_lane_o;
    logic [31:0]   pkt_count_o;
    logic          err_zero_len_o;

    packet_buffer_read_scheduler dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .desc_len_i     (desc_len_i),
        .desc_valid_i   (desc_valid_i),
        .desc_ready_o   (desc_ready_o),
        .lane_tdata_i   (lane_tdata_i),
        .lane_tvalid_i  (lane_tvalid_i),
        .lane_tready_o  (lane_tready_o),
        .m_tdata_o      (m_tdata_o),
        .m_tvalid_o     (m_tvalid_o),
        .m_tlast_o      (m_tlast_o),
        .m_tready_i     (m_tready_i),
        .m_lane_o       (m_lane_o),
        .pkt_count_o    (pkt_count_o),
        .err_zero_len_o (err_zero_len_o)
    );

    always #5 clk_i = ~clk_i;

    int         dq [NL][$];
    logic [7:0] bq [NL][$];
    beat_t      exp_q [$];
    int         blk [NL];
    int checks, errors;
    int cyc, grant_cyc, last_cyc, beats_cnt;
    int exp_pkts, exp_err, exp_pops, err_seen, pops_seen;
    int model_ptr, tready_pct, gap_pct, starve_lane;
    bit strict, tog, in_pkt, have_prev;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(int lane, int len, int base);
        dq[lane].push_back(len);
        exp_pops++;
        for (int j = 0; j < len; j++) begin
            bq[lane].push_back(base >= 0 ? 8'(base + j) : 8'($urandom));
        end
    endtask

    function automatic bit all_desc_empty();
        for (int l = 0; l < NL; l++) begin
            if (dq[l].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Whole-packet round-robin over the queued descriptors.
    task automatic build_expected();
        int tq [NL][$];
        int bi [NL];
        bit any;
        for (int l = 0; l < NL; l++) begin
            tq[l] = dq[l];
            bi[l] = 0;
        end
        do begin
            any = 1'b0;
            for (int k = 0; k < NL; k++) begin
                int l;
                int len;
                l = (model_ptr + k) % NL;
                if (!any && tq[l].size() > 0) begin
                    any = 1'b1;
                    len = tq[l].pop_front();
                    model_ptr = (l + 1) % NL;
                    if (len == 0) exp_err++;
                    else begin
                        exp_pkts++;
                        for (int j = 0; j < len; j++) begin
                            exp_q.push_back(beat_t'{lane: l,
                                data: bq[l][bi[l]], last: (j == len - 1)});
                            bi[l]++;
                        end
                    end
                end
            end
        end while (any);
    endtask

    task automatic step();
        bit    forced [NL];
        beat_t b;
        @(negedge clk_i);
        for (int l = 0; l < NL; l++) begin
            forced[l] = 1'b0;
            desc_valid_i[l] = dq[l].size() > 0;
            desc_len_i[l] = (dq[l].size() > 0) ? LW'(dq[l][0]) : '0;
            lane_tdata_i[l] = (bq[l].size() > 0) ? bq[l][0] : 8'h00;
            if (blk[l] > 0) begin
                blk[l]--;
                forced[l] = 1'b1;
                lane_tvalid_i[l] = 1'b0;
            end else begin
                lane_tvalid_i[l] = (bq[l].size() > 0)
                    && ($urandom_range(99) >= gap_pct);
            end
        end
        if (tog) m_tready_i = ~m_tready_i;
        else m_tready_i = ($urandom_range(99) < tready_pct);
        #1;
        cyc++;
        if (err_zero_len_o) err_seen++;
        if (desc_ready_o != '0) begin
            check("desc_ready_onehot", 64'($onehot(desc_ready_o)), 1);
            check("grant_mid_pkt", 64'(in_pkt), 0);
            grant_cyc = cyc;
            for (int l = 0; l < NL; l++) begin
                if (desc_ready_o[l]) begin
                    pops_seen++;
                    check("desc_pop_valid", 64'(dq[l].size() > 0), 1);
                    if (dq[l].size() > 0) void'(dq[l].pop_front());
                end
            end
        end
        if (lane_tready_o != '0) begin
            if (exp_q.size() == 0) check("tready_idle", lane_tready_o, 0);
            else begin
                check("tready_sel", lane_tready_o,
                      64'(NL'(1) << exp_q[0].lane));
                check("tready_mirror", 64'(m_tready_i), 1);
            end
        end
        if (exp_q.size() > 0 && forced[exp_q[0].lane])
            check("starve_tvalid", 64'(m_tvalid_o), 0);
        if (m_tvalid_o && m_tready_i) begin
            if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
            else begin
                b = exp_q.pop_front();
                check("beat_lane", m_lane_o, b.lane);
                check("beat_data", m_tdata_o, b.data);
                check("beat_last", 64'(m_tlast_o), 64'(b.last));
                if (strict) begin
                    if (!in_pkt) begin
                        check("first_beat_lat", cyc - grant_cyc, 1);
                        if (have_prev)
                            check("idle_gap", grant_cyc - last_cyc, 1);
                    end else begin
                        check("beat_spacing", cyc - last_cyc, 1);
                    end
                end
                if (!in_pkt && b.lane == starve_lane) begin
                    blk[b.lane] = 4;
                    starve_lane = -1;
                end
                in_pkt    = !b.last;
                last_cyc  = cyc;
                have_prev = 1'b1;
                beats_cnt++;
            end
        end
        for (int l = 0; l < NL; l++) begin
            if (lane_tready_o[l] && lane_tvalid_i[l] && bq[l].size() > 0)
                void'(bq[l].pop_front());
        end
    endtask

    task automatic run();
        int n;
        build_expected();
        have_prev = 1'b0;
        n = 0;
        while ((exp_q.size() > 0 || !all_desc_empty()) && n < 3000) begin
            step();
            n++;
        end
        check("run_timeout", 64'(n < 3000), 1);
        repeat (3) step();
        check("pkt_count", pkt_count_o, exp_pkts);
        check("zero_len_errs", err_seen, exp_err);
        check("desc_pops", pops_seen, exp_pops);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_desc_ready"}, desc_ready_o, 0);
        check({tag, "_lane_tready"}, lane_tready_o, 0);
        check({tag, "_tvalid"}, 64'(m_tvalid_o), 0);
        check({tag, "_tlast"}, 64'(m_tlast_o), 0);
        check({tag, "_pkt_count"}, pkt_count_o, 0);
        check({tag, "_lane"}, m_lane_o, 0);
        check({tag, "_err"}, 64'(err_zero_len_o), 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        check_idle("in_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_idle("post_reset");
    endtask

    initial begin
        int start;
        int n;
        rst_i = 1'b1;
        m_tready_i = 1'b0;
        desc_valid_i = '0;
        lane_tvalid_i = '0;
        for (int l = 0; l < NL; l++) begin
            desc_len_i[l] = '0;
            lane_tdata_i[l] = '0;
            blk[l] = 0;
        end
        checks = 0; errors = 0; cyc = 0; grant_cyc = 0; last_cyc = 0;
        beats_cnt = 0; exp_pkts = 0; exp_err = 0; exp_pops = 0;
        err_seen = 0; pops_seen = 0; model_ptr = 0; starve_lane = -1;
        tready_pct = 100; gap_pct = 0; strict = 1; tog = 0;
        in_pkt = 0; have_prev = 0;

        load(0, 2, 'h10); load(2, 2, 'h20); load(7, 2, 'h70);
        load(0, 2, 'h30);
        do_reset();
        run();

        load(3, 5, 'hA0);
        run();

        strict = 0; tog = 1;
        load(1, 4, 'h40);
        run();
        tog = 0;

        load(5, 0, 0); load(6, 1, 'h60);
        run();

        starve_lane = 2;
        load(2, 3, 'h50); load(4, 1, 'h55);
        run();

        tready_pct = 70; gap_pct = 20;
        for (int r = 0; r < 6; r++) begin
            for (int l = 0; l < NL; l++) begin
                repeat ($urandom_range(2)) load(l, $urandom_range(6), -1);
            end
            run();
        end

        tready_pct = 100; gap_pct = 0;
        load(0, 6, 'hC0);
        build_expected();
        start = beats_cnt;
        n = 0;
        while (beats_cnt - start < 2 && n < 100) begin
            step();
            n++;
        end
        check("mid_reset_timeout", 64'(n < 100), 1);
        exp_q.delete();
        exp_pkts = 0; exp_err = 0; exp_pops = 0;
        err_seen = 0; pops_seen = 0; in_pkt = 0; model_ptr = 0;
        do_reset();
        for (int l = 0; l < NL; l++) begin
            dq[l].delete();
            bq[l].delete();
            blk[l] = 0;
        end
        strict = 1;
        load(0, 3, 'hD0);
        run();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_buffer_read_scheduler.md
Name: packet_buffer_read_scheduler

Overview:
Drains the per-lane byte FIFOs of the packet buffer into a single byte-wide AXI4-Stream master, one whole packet at a time. Each lane supplies a packet-length descriptor alongside its byte stream. The scheduler round-robins between lanes that hold a pending descriptor and streams exactly that many bytes with tlast on the final byte. It sits between the packet buffer lane outputs and the downstream parser/capture logic.

Parameters:
NUM_LANES, 8, number of buffer lanes (power of two, >=2)
DATA_WIDTH, 8, lane/output data width in bits
LEN_WIDTH, PKT_LEN_WIDTH (11), descriptor length width in bytes

Ports:
clk_i  in  1  clock
rst_i  in  1  reset: synchronous, active-high; all state cleared on the rising edge where rst_i=1
desc_len_i[NUM_LANES]  in  LEN_WIDTH  per-lane packet length in bytes
desc_valid_i[NUM_LANES]  in  1  per-lane descriptor valid
desc_ready_o[NUM_LANES]  out  1  per-lane descriptor pop (one-cycle pulse)
lane_tdata_i[NUM_LANES]  in  DATA_WIDTH  per-lane FIFO byte
lane_tvalid_i[NUM_LANES]  in  1  per-lane byte valid
lane_tready_o[NUM_LANES]  out  1  per-lane byte read enable
m_tdata_o  out  DATA_WIDTH  output byte
m_tvalid_o  out  1  output valid
m_tlast_o  out  1  last byte of packet
m_tready_i  in  1  downstream ready
m_lane_o  out  clog2(NUM_LANES)  lane currently being streamed
pkt_count_o  out  32  packets fully streamed since reset (wraps)
err_zero_len_o  out  1  one-cycle pulse: zero-length descriptor discarded

Behaviour:
- Reset values: state=ARB, rr pointer=0, remaining=0, m_lane_o=0, pkt_count_o=0, err_zero_len_o=0. All desc_ready_o, lane_tready_o, m_tvalid_o and m_tlast_o are 0 while rst_i=1 and in the first cycle after reset.
- FSM states: ARB and STREAM.
- ARB:
  - Round-robin grant over desc_valid_i. Search starts at the rr pointer; lowest index at or after the pointer wins, wrapping modulo NUM_LANES.
  - On a grant to lane g: desc_ready_o[g]=1 combinationally in the same cycle. Latch remaining=desc_len_i[g] and m_lane_o=g. Set rr pointer=(g+1) mod NUM_LANES.
  - If desc_len_i[g]==0: pulse err_zero_len_o next cycle, stay in ARB, no output beats. Otherwise go to STREAM.
  - No valid descriptor: stay in ARB, all outputs idle.
- STREAM:
  - Combinational passthrough: m_tdata_o=lane_tdata_i[sel], m_tvalid_o=lane_tvalid_i[sel], lane_tready_o[sel]=m_tready_i. All other lane_tready_o are 0; desc_ready_o are all 0.
  - m_tlast_o=m_tvalid_o && remaining==1.
  - remaining decrements on each beat (m_tvalid_o && m_tready_i).
  - On the beat with tlast: pkt_count_o increments and the FSM returns to ARB. This gives one idle cycle between packets.
- Latency: descriptor granted in cycle N; first byte can transfer in N+1.
- Downstream backpressure: lane_tready_o follows m_tready_i, so no byte is lost or duplicated. m_tdata_o is stable only while lane data is stable, which the lane FIFO guarantees.
- Lane starvation (lane_tvalid_i=0 mid-packet): hold in STREAM with m_tvalid_o=0. There is no timeout and no lane switching mid-packet.
- Simultaneous descriptors on all lanes: strict rotation 0,1,...,NUM_LANES-1,0.
- rst_i mid-packet: the packet is abandoned with no tlast; the descriptor is already consumed.
- Lengths are not clamped; upstream guarantees <= MAX_ETH_FRAME_LENGTH.

Decomposition:
- packet_buffer_pkg gains:
  - PKT_LEN_WIDTH = $clog2(MAX_ETH_FRAME_LENGTH+1)
  - typedef sched_state_t {SCHED_ARB, SCHED_STREAM}
- Sub-module rr_arbiter (NUM_REQ; inputs req, ptr; outputs grant_idx, grant_valid): purely combinational priority rotation, reusable elsewhere.

Test Plan:
- Lane 3 descriptor len=5, bytes 0xA0..0xA4, m_tready_i=1 -> five beats on consecutive cycles, tlast on 0xA4, m_lane_o=3, pkt_count_o=1, desc_ready_o[3] pulses once.
- Lanes 0, 2, 7 all valid with len=2 -> packet order 0,2,7; then lane 0 again only after lane 7; one idle cycle between packets.
- Lane 1 len=4 with m_tready_i toggling 1,0,1,0 -> exactly four accepted beats in order; lane_tready_o[1] mirrors m_tready_i; tlast only on the 4th accepted beat.
- Lane 5 len=0 followed by lane 6 len=1 -> err_zero_len_o pulses once, no beat for lane 5, lane 6 byte emitted with tlast, pkt_count_o=1.
- Lane 2 len=3, lane_tvalid_i drops for 4 cycles after the first byte -> m_tvalid_o=0 during the gap, no other lane granted, remaining bytes resume with tlast on the third.
- rst_i asserted after 2 of 6 bytes -> next cycle all outputs 0, pkt_count_o=0; a fresh lane 0 descriptor afterwards streams normally.
